mul_div_unit: RTL

Iterative MIPS multiply/divide unit owning the architectural HI and LO registers. It sits directly downstream of the register file and takes rs/rt from its two read ports. It executes MULT, MULTU, DIV and DIVU at one bit per cycle, and MTHI/MTLO in one cycle. It drives HI/LO to the writeback mux for MFHI/MFLO and raises busy so the control unit can stall.

---
 rtl/mul_div_unit.sv | 111 +++++++++++
 1 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MIPS multiply/divide unit (one bit per cycle) owning HI/LO.
// Signed ops run on magnitudes and fix signs in a final SIGN cycle.
module mul_div_unit (
    input  logic        mul_div_unit_clk,
    input  logic        mul_div_unit_rst,
    input  logic        mul_div_unit_start,
    input  logic [2:0]  mul_div_unit_op,
    input  logic [31:0] mul_div_unit_src1,
    input  logic [31:0] mul_div_unit_src2,
    output logic [31:0] mul_div_unit_hi,
    output logic [31:0] mul_div_unit_lo,
    output logic        mul_div_unit_busy,
    output logic        mul_div_unit_done,
    output logic        mul_div_unit_div_zero
);
    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] opb_q, opb_d, hi_q, hi_d, lo_q, lo_d;
    logic        is_div_q, is_div_d, neg_q, neg_d, neg_rem_q, neg_rem_d, zero_q, zero_d;
    logic        busy_q, busy_d, done_q, done_d, dz_q, dz_d;

    logic        go, sgn, idle_start, wr;
    logic [31:0] mag1, mag2, quo, rem;
    logic [32:0] sum;
    logic [33:0] diff;
    logic [63:0] step, prod;

    assign mul_div_unit_hi       = hi_q;
    assign mul_div_unit_lo       = lo_q;
    assign mul_div_unit_busy     = busy_q;
    assign mul_div_unit_done     = done_q;
    assign mul_div_unit_div_zero = dz_q;

    always_ff @(posedge mul_div_unit_clk or posedge mul_div_unit_rst) begin
        if (mul_div_unit_rst) state_q <= IDLE;
        else state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == IDLE ? (go ? CALC : IDLE) :
                  state_q == CALC ? (cnt_q == 5'd31 ? SIGN : CALC) : IDLE;
    end

    // Datapath: multiply shifts the product right (LSB first); divide shifts
    // remainder:quotient left and restores on borrow (MSB first).
    always_comb begin
        idle_start = mul_div_unit_start && state_q == IDLE;
        go         = idle_start && !mul_div_unit_op[2];
        sgn        = !mul_div_unit_op[0];
        mag1       = sgn && mul_div_unit_src1[31] ? -mul_div_unit_src1 : mul_div_unit_src1;
        mag2       = sgn && mul_div_unit_src2[31] ? -mul_div_unit_src2 : mul_div_unit_src2;
        sum        = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
        diff       = {1'b0, acc_q[63:31]} - {2'b0, opb_q};
        step       = !is_div_q ? {sum, acc_q[31:1]} :
                     diff[33] ? {acc_q[62:0], 1'b0} : {diff[31:0], acc_q[30:0], 1'b1};
        prod       = neg_q ? -acc_q : acc_q;
        quo        = neg_q ? -acc_q[31:0] : acc_q[31:0];
        rem        = neg_rem_q ? -acc_q[63:32] : acc_q[63:32];
        wr         = state_q == SIGN && !(is_div_q && zero_q);
        cnt_d      = go ? 5'd0 : state_q == CALC ? cnt_q + 5'd1 : cnt_q;
        acc_d      = go ? {32'd0, mul_div_unit_op[1] ? mag1 : mag2} : state_q == CALC ? step : acc_q;
        opb_d      = go ? (mul_div_unit_op[1] ? mag2 : mag1) : opb_q;
        is_div_d   = go ? mul_div_unit_op[1] : is_div_q;
        neg_d      = go ? sgn && (mul_div_unit_src1[31] ^ mul_div_unit_src2[31]) : neg_q;
        neg_rem_d  = go ? sgn && mul_div_unit_src1[31] : neg_rem_q;
        zero_d     = go ? mul_div_unit_src2 == 32'd0 : zero_q;
        hi_d       = wr ? (is_div_q ? rem : prod[63:32]) :
                     idle_start && mul_div_unit_op == OP_MTHI ? mul_div_unit_src1 : hi_q;
        lo_d       = wr ? (is_div_q ? quo : prod[31:0]) :
                     idle_start && mul_div_unit_op == OP_MTLO ? mul_div_unit_src1 : lo_q;
        busy_d     = state_d != IDLE;
        done_d     = state_q == SIGN;
        dz_d       = state_q == SIGN && is_div_q && zero_q;
    end

    always_ff @(posedge mul_div_unit_clk or posedge mul_div_unit_rst) begin
        if (mul_div_unit_rst) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            zero_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            zero_q    <= zero_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
        end
    end
endmodule
